// File: rtl/decode_imm_ctrl_pkg.sv
// Shared definitions for the decode/immediate slice: immediate format
// encodings, RV32 opcode constants, the canonical NOP and the IF/ID
// occupancy state encoding.
package decode_imm_ctrl_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HELD   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/decode_imm_ctrl_if.sv
// Fetch-side inputs, pipeline control and E-stage outputs of decode_imm_ctrl.
// master: the pipeline around the block; slave: decode_imm_ctrl itself.
interface decode_imm_ctrl_if;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] ImmExtE;
  logic [2:0]  ImmSrcE;
  logic [31:0] PCE;
  logic        ValidE;
  logic        IllegalE;
  logic [3:0]  StallCntD;
  logic        StallTimeoutD;

  modport master (
    output InstrF, PCF, ValidF, StallD, FlushD, FlushE,
    input  ImmExtE, ImmSrcE, PCE, ValidE, IllegalE, StallCntD, StallTimeoutD
  );

  modport slave (
    input  InstrF, PCF, ValidF, StallD, FlushD, FlushE,
    output ImmExtE, ImmSrcE, PCE, ValidE, IllegalE, StallCntD, StallTimeoutD
  );
endinterface

// File: rtl/imm_fmt_dec.sv
// Opcode-to-immediate-format decoder (purely combinational).
// Build option: DECODE_ILLEGAL_DET_EN flags unknown opcodes as illegal and
// zeroes their immediate; without it unknown opcodes decode as I format.
module imm_fmt_dec
  import decode_imm_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       valid,
  output imm_src_e   imm_src,
  output logic       zero_imm,
  output logic       illegal
);

  // Bubbles decode as a zero I immediate with no illegal flag.
  always_comb begin
    imm_src  = IMM_I;
    zero_imm = 1'b0;
    illegal  = 1'b0;
    if (!valid) begin
      zero_imm = 1'b1;
    end else begin
      case (opcode)
        OP_IMM, OP_LOAD, OP_JALR: imm_src = IMM_I;
        OP_STORE:                 imm_src = IMM_S;
        OP_BRANCH:                imm_src = IMM_B;
        OP_LUI, OP_AUIPC:         imm_src = IMM_U;
        OP_JAL:                   imm_src = IMM_J;
        OP_REG:                   zero_imm = 1'b1;
        default: begin
`ifdef DECODE_ILLEGAL_DET_EN
          illegal  = 1'b1;
          zero_imm = 1'b1;
`else
          imm_src  = IMM_I;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_imm_ctrl.sv
// IF/ID register, immediate extension and ID/EX register for the immediate
// path, plus an IF/ID occupancy FSM with a saturating stall counter.
// Build option: DECODE_ILLEGAL_DET_EN (illegal-opcode detection, see imm_fmt_dec).
module decode_imm_ctrl #(
  parameter int XLEN    = 32,
  parameter int SAT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  decode_imm_ctrl_if.slave bus
);
  import decode_imm_ctrl_pkg::*;

  localparam logic [3:0] SAT = 4'(SAT_MAX);

  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic            valid_d;
  logic            valid_d_next;
  occ_state_e      state;
  logic [3:0]      stall_cnt;

  imm_src_e        imm_src;
  logic            zero_imm;
  logic            illegal;
  logic [XLEN-1:0] imm_ext;

  logic [XLEN-1:0] imm_e;
  imm_src_e        src_e;
  logic [XLEN-1:0] pc_e;
  logic            valid_e;
  logic            illegal_e;

  // IF/ID register: flush beats stall beats capture; PC is left alone on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= NOP_INSTR;
      pc_d    <= '0;
      valid_d <= 1'b0;
    end else if (bus.FlushD) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!bus.StallD) begin
      instr_d <= bus.InstrF;
      pc_d    <= bus.PCF;
      valid_d <= bus.ValidF;
    end
  end

  // Mirror of the ValidD update so the FSM can look one cycle ahead.
  always_comb begin
    valid_d_next = 1'b0;
    if (!bus.FlushD) valid_d_next = bus.StallD ? valid_d : bus.ValidF;
  end

  // Occupancy FSM and stall counter; the counter only advances once the
  // FSM has already settled in HELD, so the first stalled edge does not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      stall_cnt <= '0;
    end else if (bus.FlushD) begin
      state     <= ST_EMPTY;
      stall_cnt <= '0;
    end else begin
      if (!valid_d_next)    state <= ST_EMPTY;
      else if (bus.StallD)  state <= ST_HELD;
      else                  state <= ST_ACTIVE;

      if (!bus.StallD)
        stall_cnt <= '0;
      else if (state == ST_HELD && stall_cnt != SAT)
        stall_cnt <= stall_cnt + 4'd1;
    end
  end

  imm_fmt_dec u_imm_fmt_dec (
    .opcode   (instr_d[6:0]),
    .valid    (valid_d),
    .imm_src  (imm_src),
    .zero_imm (zero_imm),
    .illegal  (illegal)
  );

  // Immediate extension from InstrD[31:7] by format.
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
      IMM_S: imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B: imm_ext = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                        instr_d[30:25], instr_d[11:8], 1'b0};
      IMM_U: imm_ext = {instr_d[31:12], 12'h000};
      IMM_J: imm_ext = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                        instr_d[20], instr_d[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
    if (zero_imm) imm_ext = '0;
  end

  // ID/EX register: FlushE or StallD inserts a bubble with PCE held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_e     <= '0;
      src_e     <= IMM_I;
      pc_e      <= '0;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else if (bus.FlushE || bus.StallD) begin
      imm_e     <= '0;
      src_e     <= IMM_I;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else begin
      imm_e     <= imm_ext;
      src_e     <= imm_src;
      pc_e      <= pc_d;
      valid_e   <= valid_d;
      illegal_e <= illegal;
    end
  end

  assign bus.ImmExtE       = imm_e;
  assign bus.ImmSrcE       = src_e;
  assign bus.PCE           = pc_e;
  assign bus.ValidE        = valid_e;
  assign bus.IllegalE      = illegal_e;
  assign bus.StallCntD     = stall_cnt;
  assign bus.StallTimeoutD = (stall_cnt == SAT);

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Directed bench for decode_imm_ctrl with hand-computed expectations.
module tb_decode_imm_ctrl;
  import decode_imm_ctrl_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] src;
    logic [31:0] ill;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  vec_t vec [10];

  decode_imm_ctrl_if bus ();

  decode_imm_ctrl #(.XLEN(32), .SAT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
    bus.InstrF = instr;
    bus.PCF    = pc;
    bus.ValidF = v;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_imm"}, bus.ImmExtE, 32'h0);
    chk({tag, "_src"}, 32'(bus.ImmSrcE), 32'h0);
    chk({tag, "_pce"}, bus.PCE, 32'h0);
    chk({tag, "_vld"}, 32'(bus.ValidE), 32'h0);
    chk({tag, "_ill"}, 32'(bus.IllegalE), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.StallCntD), 32'h0);
    chk({tag, "_tmo"}, 32'(bus.StallTimeoutD), 32'h0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    vec[0] = '{32'hFFF00093, 32'hFFFFFFFF, 32'd0, 32'd0};
    vec[1] = '{32'hFE112E23, 32'hFFFFFFFC, 32'd1, 32'd0};
    vec[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 32'd2, 32'd0};
    vec[3] = '{32'h123452B7, 32'h12345000, 32'd3, 32'd0};
    vec[4] = '{32'h0080006F, 32'h00000008, 32'd4, 32'd0};
    vec[5] = '{32'h002081B3, 32'h00000000, 32'd0, 32'd0};
    vec[6] = '{32'h00412083, 32'h00000004, 32'd0, 32'd0};
    vec[7] = '{32'hFFC08067, 32'hFFFFFFFC, 32'd0, 32'd0};
    vec[8] = '{32'hABCDE017, 32'hABCDE000, 32'd3, 32'd0};
`ifdef DECODE_ILLEGAL_DET_EN
    vec[9] = '{32'h0010007F, 32'h00000000, 32'd0, 32'd1};
`else
    vec[9] = '{32'h0010007F, 32'h00000001, 32'd0, 32'd0};
`endif

    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    bus.FlushE = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk_zero_outputs("reset");
    chk("reset_validd", 32'(dut.valid_d), 32'h0);
    chk("reset_instrd", dut.instr_d, 32'h00000013);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back decode, E outputs one edge behind D
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(vec[i].instr, 32'h1000 + 32'(4 * i), 1'b1);
      else        drive(32'h0, 32'h0, 1'b0);
      tick();
      if (i > 0) begin
        chk($sformatf("seq%0d_imm", i - 1), bus.ImmExtE, vec[i-1].imm);
        chk($sformatf("seq%0d_src", i - 1), 32'(bus.ImmSrcE), vec[i-1].src);
        chk($sformatf("seq%0d_vld", i - 1), 32'(bus.ValidE), 32'h1);
        chk($sformatf("seq%0d_ill", i - 1), 32'(bus.IllegalE), vec[i-1].ill);
        chk($sformatf("seq%0d_pce", i - 1), bus.PCE, 32'h1000 + 32'(4 * (i - 1)));
      end
    end
    tick();
    chk("bubble_vld", 32'(bus.ValidE), 32'h0);
    chk("bubble_ill", 32'(bus.IllegalE), 32'h0);
    chk("bubble_imm", bus.ImmExtE, 32'h0);

    // Long stall with a valid instruction held in D
    drive(32'h00500093, 32'h2000, 1'b1);
    tick();
    bus.StallD = 1'b1;
    drive(32'h00700093, 32'h2004, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("stall%0d_vld", n), 32'(bus.ValidE), 32'h0);
      chk($sformatf("stall%0d_cnt", n), 32'(bus.StallCntD), (n - 1 > 15) ? 32'd15 : 32'(n - 1));
      chk($sformatf("stall%0d_tmo", n), 32'(bus.StallTimeoutD), (n - 1 >= 15) ? 32'd1 : 32'd0);
    end
    bus.StallD = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    tick();
    chk("release_vld", 32'(bus.ValidE), 32'h1);
    chk("release_imm", bus.ImmExtE, 32'h5);
    chk("release_pce", bus.PCE, 32'h2000);
    chk("release_cnt", 32'(bus.StallCntD), 32'h0);
    chk("release_tmo", 32'(bus.StallTimeoutD), 32'h0);
    tick();
    chk("release_once", 32'(bus.ValidE), 32'h0);

    // FlushD together with StallD while the counter is running
    drive(32'h00500093, 32'h2100, 1'b1);
    tick();
    bus.StallD = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    repeat (4) tick();
    chk("prefl_cnt", 32'(bus.StallCntD), 32'h3);
    bus.FlushD = 1'b1;
    tick();
    chk("flsh_validd", 32'(dut.valid_d), 32'h0);
    chk("flsh_state", 32'(dut.state), 32'(ST_EMPTY));
    chk("flsh_cnt", 32'(bus.StallCntD), 32'h0);
    chk("flsh_vld", 32'(bus.ValidE), 32'h0);
    bus.FlushD = 1'b0;
    bus.StallD = 1'b0;

    // FlushE alone: bubble in E, PCE held
    drive(32'hFFF00093, 32'h3000, 1'b1);
    tick();
    drive(32'hFE112E23, 32'h3004, 1'b1);
    tick();
    chk("prefe_vld", 32'(bus.ValidE), 32'h1);
    chk("prefe_pce", bus.PCE, 32'h3000);
    bus.FlushE = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    tick();
    chk("flshe_vld", 32'(bus.ValidE), 32'h0);
    chk("flshe_imm", bus.ImmExtE, 32'h0);
    chk("flshe_src", 32'(bus.ImmSrcE), 32'h0);
    chk("flshe_pce", bus.PCE, 32'h3000);
    bus.FlushE = 1'b0;

    // Asynchronous reset in the middle of a stall
    drive(32'h00300093, 32'h4000, 1'b1);
    tick();
    drive(32'h00400093, 32'h4004, 1'b1);
    tick();
    bus.StallD = 1'b1;
    repeat (4) tick();
    chk("prerst_cnt", 32'(bus.StallCntD), 32'h3);
    chk("prerst_pce", bus.PCE, 32'h4000);
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    chk("midrst_validd", 32'(dut.valid_d), 32'h0);
    #1 rst = 1'b0;
    bus.StallD = 1'b0;
    drive(32'h0080006F, 32'h5000, 1'b1);
    tick();
    drive(32'h0, 32'h0, 1'b0);
    tick();
    chk("postrst_vld", 32'(bus.ValidE), 32'h1);
    chk("postrst_imm", bus.ImmExtE, 32'h8);
    chk("postrst_src", 32'(bus.ImmSrcE), 32'h4);
    chk("postrst_pce", bus.PCE, 32'h5000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_imm_ctrl.md
DECODE_IMM_CTRL -- requirements
Module: decode_imm_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter SAT_MAX, default 15, stall-counter saturation value (4-bit max).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 InstrF  in  32  fetched instruction.
REQ-006 PCF  in  32  fetched PC.
REQ-007 ValidF  in  1  InstrF/PCF carry a real instruction.
REQ-008 StallD  in  1  hold the IF/ID register.
REQ-009 FlushD  in  1  squash the IF/ID register.
REQ-010 FlushE  in  1  insert a bubble into ID/EX.
REQ-011 ImmExtE  out  32  extended immediate, E stage.
REQ-012 ImmSrcE  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
REQ-013 PCE  out  32  PC, E stage.
REQ-014 ValidE  out  1  E-stage slot holds a real instruction.
REQ-015 IllegalE  out  1  unknown opcode in E stage (macro-dependent, see REQ-037).
REQ-016 StallCntD  out  4  consecutive-stall counter.
REQ-017 StallTimeoutD  out  1  StallCntD equals SAT_MAX.

Function
REQ-018 IF/ID register: FlushD, then StallD, then capture, in that priority order.
- On FlushD: InstrD=0x00000013, ValidD=0.
- On StallD (no flush): hold.
- Otherwise: load InstrF, PCF, ValidF.
REQ-019 Opcode decode on InstrD[6:0]:
- 0010011, 0000011, 1100111 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
- 0110011 (R-type) -> I format, but immediate forced to 0.
- Any other opcode -> illegal.
REQ-020 Immediate source field SHALL be InstrD[31:7].
REQ-021 I immediate: sign-extend InstrD[31:20].
REQ-022 S immediate: sign-extend {InstrD[31:25], InstrD[11:7]}.
REQ-023 B immediate: sign-extend {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
REQ-024 U immediate: {InstrD[31:12], 12'h000}.
REQ-025 J immediate: sign-extend {InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 0}.
REQ-026 ID/EX register, priority order:
- FlushE: ValidE=0, ImmExtE=0, ImmSrcE=0, IllegalE=0, PCE held.
- StallD (no FlushE): load the bubble values above.
- Otherwise: load decoded values with ValidE=ValidD.
REQ-027 Latency: an instruction captured into D at edge k SHALL appear on the E outputs after edge k+1, absent stall or flush.
REQ-028 Occupancy FSM states:
- EMPTY: ValidD=0.
- ACTIVE: ValidD=1 and StallD=0.
- HELD: ValidD=1 and StallD=1.
REQ-029 FSM next state is computed from the next ValidD and the current StallD. FlushD forces EMPTY from any state.
REQ-030 StallCntD: increments each cycle the FSM is in HELD and StallD=1, saturating at SAT_MAX. Clears on any cycle with StallD=0 or FlushD=1.
REQ-031 If FlushD and StallD are asserted together, flush SHALL win for both the register and the counter.
REQ-032 When ValidD=0, decode SHALL emit I format, immediate 0 and IllegalE source 0, so no illegal flag is raised for bubbles.

Reset
REQ-033 rst SHALL immediately set:
- InstrD=0x00000013, ValidD=0, PCD=0.
- FSM=EMPTY, StallCntD=0, StallTimeoutD=0.
- ImmExtE=0, ImmSrcE=0, PCE=0, ValidE=0, IllegalE=0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override all other inputs.
REQ-035 After deassertion, the first rising edge SHALL behave as normal capture.

Configuration
REQ-036 Macro DECODE_ILLEGAL_DET_EN.
REQ-037 With the macro defined:
- An unknown opcode with ValidD=1 sets IllegalE=1.
- ValidE still follows ValidD.
- ImmExtE=0 for that instruction.
REQ-038 Without the macro:
- IllegalE is tied to 0.
- Unknown opcodes decode as I format.

Structure
REQ-039 A shared package SHALL hold:
- ImmSrc encodings and opcode constants.
- The NOP constant 0x00000013.
- The FSM state enum.
REQ-040 The combinational opcode-to-format decoder SHALL be one sub-module, imm_fmt_dec. Extension and registers stay in decode_imm_ctrl.

Verification
REQ-041 0xFFF00093 (addi x1,x0,-1), ValidF=1 -> after 2 edges: ImmExtE=0xFFFFFFFF, ImmSrcE=000, ValidE=1.
REQ-042 Back-to-back sequence, one instruction per cycle:
- 0xFE112E23 -> ImmExtE=0xFFFFFFFC, S.
- 0xFE000CE3 -> ImmExtE=0xFFFFFFF8, B.
- 0x123452B7 -> ImmExtE=0x12345000, U.
REQ-043 StallD held 20 cycles with a valid instruction in D:
- ValidE=0 during the stall.
- StallCntD reaches 15 and stays there; StallTimeoutD=1.
- Release -> instruction emerges once, counter returns to 0.
REQ-044 FlushD and StallD asserted together -> next cycle ValidD=0, FSM=EMPTY, StallCntD=0; FlushE alone -> ValidE=0, ImmExtE=0.
REQ-045 Opcode 0x7F with ValidF=1:
- Macro defined -> IllegalE=1, ImmExtE=0.
- Macro undefined -> IllegalE=0.
REQ-046 rst pulsed asynchronously mid-stall -> all outputs 0 before the next clock edge.
